// File: rtl/risc_v_mike_mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX_DATA/STATUS/CTRL registers, a byte FIFO
// and an 8N1 serialiser with a registered, glitch-free tx line.
module risc_v_mike_mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_mmio_addr,
    input  logic        data_mmio_wr_addr_val,
    input  logic [31:0] data_mmio_wr_data,
    output logic [31:0] data_mmio_rd_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;

    logic [29:0] word_addr;
    logic [29:0] base_word;
    logic        hit_data, hit_status, hit_ctrl;
    logic        full, empty;
    logic        push_req, push, pop, ovf_evt, ovf_clr, ctrl_wr;
    logic [4:0]  count5;
    logic        unused_bits;

    assign word_addr  = data_mmio_addr[31:2];
    assign base_word  = BASE_ADDR[31:2];
    assign hit_data   = (word_addr == base_word);
    assign hit_status = (word_addr == base_word + 30'd1);
    assign hit_ctrl   = (word_addr == base_word + 30'd2);

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign count5 = 5'(count);

    // Pop is judged on pre-edge state, so a push into a full FIFO succeeds
    // only when the serialiser is taking the head byte in the same cycle.
    assign pop      = (state == IDLE) && enable && !empty;
    assign push_req = !rst && data_mmio_wr_addr_val && hit_data;
    assign push     = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;
    assign ovf_clr  = !rst && data_mmio_wr_addr_val && hit_status && data_mmio_wr_data[3];
    assign ctrl_wr  = !rst && data_mmio_wr_addr_val && hit_ctrl;

    assign unused_bits = ^{data_mmio_wr_data[31:8], data_mmio_addr[1:0]};

    always_comb begin
        data_mmio_rd_data = '0;
        if (hit_status)
            data_mmio_rd_data[8:0] = {count5, overflow, tx_busy, empty, full};
        else if (hit_ctrl)
            data_mmio_rd_data[0] = enable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= data_mmio_wr_data[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (ovf_evt)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (ctrl_wr)
                enable <= data_mmio_wr_data[0];
        end
    end

    // tx and tx_busy follow the state one cycle later, so both are pure flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= fifo_mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_v_mike_mmio_uart_tx.sv
// Directed/randomised bench for the MMIO UART transmitter; tx and tx_busy are
// compared every cycle against a frame-timing model driven by a byte queue.
module tb_risc_v_mike_mmio_uart_tx;

    localparam int          CPB    = 4;
    localparam int          FRAME  = 10 * CPB + 1;
    localparam logic [31:0] BASE   = 32'hFFFF0000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;

    logic        clk;
    logic        rst;
    logic [31:0] data_mmio_addr;
    logic        data_mmio_wr_addr_val;
    logic [31:0] data_mmio_wr_data;
    logic [31:0] data_mmio_rd_data;
    logic        tx;
    logic        tx_busy;

    risc_v_mike_mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .data_mmio_addr       (data_mmio_addr),
        .data_mmio_wr_addr_val(data_mmio_wr_addr_val),
        .data_mmio_wr_data    (data_mmio_wr_data),
        .data_mmio_rd_data    (data_mmio_rd_data),
        .tx                   (tx),
        .tx_busy              (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = -1000;     // cycles since the edge that made the first byte eligible
    logic [7:0] q[$];         // bytes expected on the line, in order

    // Line level at cycle kk: frame j occupies cycles 41j+1 .. 41j+41, with the
    // start bit sampled from local cycle 2, then 8 data bits LSB first, then stop.
    function automatic logic exp_tx(int kk);
        int j, l, p;
        logic [7:0] b;
        if (kk < 1) return 1'b1;
        j = (kk - 1) / FRAME;
        if (j >= q.size()) return 1'b1;
        l = kk - FRAME * j;
        if (l < 2 || l > FRAME) return 1'b1;
        p = (l - 2) / CPB;
        if (p == 0) return 1'b0;
        if (p > 8) return 1'b1;
        b = q[j];
        return b[p-1];
    endfunction

    function automatic logic exp_busy(int kk);
        int j, l;
        if (kk < 1) return 1'b0;
        j = (kk - 1) / FRAME;
        if (j >= q.size()) return 1'b0;
        l = kk - FRAME * j;
        return (l >= 2 && l <= FRAME);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
        check("tx", {31'd0, tx}, {31'd0, exp_tx(k)});
        check("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy(k)});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_mmio_addr        = a;
        data_mmio_wr_data     = d;
        data_mmio_wr_addr_val = 1'b1;
        tick();
        data_mmio_wr_addr_val = 1'b0;
        data_mmio_wr_data     = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
        data_mmio_addr = a;
        #1;
        check(tag, data_mmio_rd_data, expv);
    endtask

    task automatic run_to(input int kend);
        while (k < kend) tick();
    endtask

    initial begin
        logic [7:0] b;
        rst                   = 1'b1;
        data_mmio_addr        = '0;
        data_mmio_wr_addr_val = 1'b0;
        data_mmio_wr_data     = '0;
        tick();
        tick();
        rst = 1'b0;
        rd("reset_status", A_STAT, 32'h002);
        rd("reset_ctrl", A_CTRL, 32'h0);

        // single frame 0xA5, then one random byte
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd("ctrl_enable", A_CTRL, 32'h1);
        for (int unsigned f = 0; f < 2; f++) begin
            b = (f == 0) ? 8'hA5 : 8'($urandom);
            q = {b};
            k = -1000;
            wr(A_DATA, {24'($urandom), b});
            k = 0;
            run_to(FRAME + 3);
            rd("single_status", A_STAT, 32'h002);
        end

        // back-to-back: 3 bytes queued while disabled, then enabled
        wr(A_CTRL, 32'h0);
        q.delete();
        k = -1000;
        for (int unsigned i = 0; i < 3; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(A_DATA, {24'd0, b});
        end
        rd("b2b_queued", A_STAT, 32'h030);
        wr(A_CTRL, 32'h1);
        k = 0;
        run_to(3 * FRAME + 2);
        rd("b2b_done", A_STAT, 32'h002);

        // fill with enable=0, overflow, clear
        wr(A_CTRL, 32'h0);
        q.delete();
        k = -1000;
        for (int unsigned i = 0; i < 8; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(A_DATA, {24'd0, b});
        end
        rd("fill_full", A_STAT, 32'h081);
        rd("fill_addr_lsbs", A_STAT + 32'h3, 32'h081);
        rd("txdata_reads0", A_DATA, 32'h0);
        wr(A_DATA, 32'h0000_00FF);
        rd("fill_overflow", A_STAT, 32'h089);
        wr(A_STAT, 32'h8);
        rd("ovf_cleared", A_STAT, 32'h081);

        // full-with-pop: byte written in the pop cycle is accepted
        wr(A_CTRL, 32'h1);
        k = 0;
        b = 8'($urandom);
        wr(A_DATA, {24'd0, b});
        rd("full_pop", A_STAT, 32'h081);
        q.push_back(b);
        run_to(9 * FRAME + 2);
        rd("drain_done", A_STAT, 32'h002);

        // disable mid-frame: frame completes, second byte stays queued
        q.delete();
        k = -1000;
        b = 8'($urandom);
        q.push_back(b);
        wr(A_DATA, {24'd0, b});
        k = 0;
        b = 8'($urandom);
        wr(A_DATA, {24'd0, b});
        run_to(9);
        wr(A_CTRL, 32'h0);
        run_to(90);
        rd("disabled_pending", A_STAT, 32'h010);
        q = {b};
        k = -1000;
        wr(A_CTRL, 32'h1);
        k = 0;
        run_to(FRAME + 2);
        rd("resumed_done", A_STAT, 32'h002);

        // reset mid-DATA, with a write presented during reset
        b = 8'($urandom);
        q = {b};
        k = -1000;
        wr(A_DATA, {24'd0, b});
        k = 0;
        run_to(10);
        rst                   = 1'b1;
        data_mmio_addr        = A_DATA;
        data_mmio_wr_data     = 32'h5A;
        data_mmio_wr_addr_val = 1'b1;
        q.delete();
        k = -1000;
        tick();
        rst                   = 1'b0;
        data_mmio_wr_addr_val = 1'b0;
        rd("rst_status", A_STAT, 32'h002);
        rd("rst_ctrl", A_CTRL, 32'h0);
        run_to(-980);

        // decode
        rd("unmapped_0xC", BASE + 32'hC, 32'h0);
        rd("txdata_0x0", A_DATA, 32'h0);
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        rd("unmapped_wr_status", A_STAT, 32'h002);
        rd("unmapped_wr_ctrl", A_CTRL, 32'h0);
        run_to(-960);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
